spi_flash_responder: RTL and testbench
======================================

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 The parameter ADDR_W SHALL default to 16 and sets the backing-memory address width; the low ADDR_W bits of the 24-bit SPI address are used.
REQ-002 The parameter SYNC_STAGES SHALL default to 2 and sets the synchronizer depth on each SPI input.
REQ-003 clk  input  1  the single system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_SPI_CLK  input  1  SPI clock from the master, mode 0.
REQ-006 i_SPI_CS  input  1  chip select, active-low.
REQ-007 i_SPI_MOSI  input  1  serial data from the master, MSB first.
REQ-008 o_SPI_MISO  output  1  serial data to the master, MSB first.
REQ-009 o_mem_addr  output  ADDR_W  backing-memory address.
REQ-010 o_mem_rd  output  1  one-cycle read strobe; data is valid on i_mem_rdata the next cycle.
REQ-011 i_mem_rdata  input  8  backing-memory read data.
REQ-012 o_mem_wr  output  1  one-cycle write strobe, qualified by o_mem_addr and o_mem_wdata.
REQ-013 o_mem_wdata  output  8  backing-memory write data.
REQ-014 o_cmd_err  output  1  one-cycle pulse when an unsupported opcode is received.

Function
REQ-015 The block SHALL synchronize i_SPI_CLK, i_SPI_CS and i_SPI_MOSI through SYNC_STAGES flops and detect SCK rise and fall edges in the clk domain.
REQ-016 The block SHALL support SCK high and low phases of at least 3 clk cycles each; behaviour at faster SCK is undefined.
REQ-017 The block SHALL sample MOSI on each detected SCK rise and update MISO on each detected SCK fall.
REQ-018 The FSM SHALL have the states IDLE, CMD, ADDR, READ, PROG, STATUS and IGNORE.
REQ-019 On CS falling, the FSM SHALL move IDLE->CMD; on CS high (synchronized), it SHALL return to IDLE from any state on the next clk.
REQ-020 After 8 CMD bits, the opcode SHALL be dispatched as follows: 0x03->ADDR (read); 0x02->ADDR (program); 0x06 sets WEL then ->IGNORE; 0x04 clears WEL then ->IGNORE; 0x05->STATUS; any other opcode pulses o_cmd_err and ->IGNORE.
REQ-021 In ADDR, the block SHALL shift in 24 address bits MSB first.
REQ-022 For a read, on the 24th address bit, the block SHALL pulse o_mem_rd with the address and load i_mem_rdata into the TX shifter one cycle later.
REQ-023 In READ, the data MSB SHALL appear on MISO at the next SCK fall.
REQ-024 In READ, on the 8th bit of each byte, the address SHALL increment with wrap (2^ADDR_W-1 -> 0), o_mem_rd SHALL pulse, and streaming SHALL continue until CS high.
REQ-025 In PROG, each complete received byte SHALL pulse o_mem_wr with o_mem_wdata equal to the byte, one clk after the 8th SCK rise.
REQ-026 In PROG, the address SHALL increment within a 256-byte page: addr[7:0] wraps and the upper bits are held.
REQ-027 If WEL=0 at opcode 0x02, the FSM SHALL enter IGNORE and issue no o_mem_wr.
REQ-028 A partial byte when CS rises SHALL be discarded.
REQ-029 On CS rise after PROG, WEL SHALL clear.
REQ-030 In STATUS, the block SHALL repeatedly shift out {6'b0, WEL, WIP}; WIP is always 0.
REQ-031 o_SPI_MISO SHALL be 0 in IDLE, CMD, ADDR and IGNORE.
REQ-032 If a CS rise coincides with a byte boundary, the completed byte's write SHALL still occur before the FSM returns to IDLE.

Reset
REQ-033 Reset SHALL force the FSM to IDLE and clear WEL and all shifters and counters.
REQ-034 Reset SHALL drive o_SPI_MISO, o_mem_rd, o_mem_wr and o_cmd_err to 0, o_mem_addr to 0 and o_mem_wdata to 0x00.
REQ-035 A reset asserted mid-transaction SHALL abort the transaction with no further strobes; a new transaction SHALL begin only on a CS falling edge after reset is released.

Structure
REQ-036 The package spi_flash_pkg SHALL hold the opcode constants (0x02, 0x03, 0x04, 0x05, 0x06), the status-bit indices (WIP=0, WEL=1) and the FSM state encoding.
REQ-037 The sub-module spi_sync SHALL implement the synchronizers plus SCK rise/fall and CS fall/rise pulse detection.
REQ-038 The top-level module SHALL implement the FSM, shifters, address counter and WEL.

Verification
REQ-039 Read test: memory[0x3AAA]=0xFA; send 0x03,0x00,0x3A,0xAA, then 8 clocks -> MISO bits 1,1,1,1,1,0,1,0; one o_mem_rd with addr 0x3AAA.
REQ-040 Program test: send WREN, then 0x02,0x00,0x30,0x00,0xAA -> one o_mem_wr with addr 0x3000 and data 0xAA; a following RDSR returns 0x00.
REQ-041 Write-protect test: send 0x02 at addr 0x3000 with data 0x55 without a prior WREN -> no o_mem_wr; WREN followed by RDSR -> 0x02.
REQ-042 Wrap test: program addr 0x30FF with 0x11,0x22 -> writes to 0x30FF then 0x3000; stream-read from 0xFFFF for 2 bytes -> o_mem_rd at 0xFFFF then 0x0000.
REQ-043 Error/abort test: opcode 0x9F -> o_cmd_err pulses once and MISO stays 0; reset asserted at the 12th address bit -> FSM in IDLE, no strobes; the next 0x03 read succeeds.
REQ-044 Partial-byte test: after WREN, send PROG plus 4 data bits, then raise CS -> no o_mem_wr and WEL cleared.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Opcodes, status-register bit positions and FSM encoding shared by the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] OP_PROG = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    localparam int STS_WIP = 0;
    localparam int STS_WEL = 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_PROG   = 3'd4;
    localparam logic [2:0] S_STATUS = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] s;
        s          = 8'h00;
        s[STS_WEL] = wel;
        s[STS_WIP] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Brings SCK/CS/MOSI into the clk domain and flags SCK and CS edges as one-cycle pulses.
// Edge pulses lag the pins by SYNC_STAGES+1 clk; all chains reset low so a held-low CS never looks like a fresh select.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    input  logic i_cs,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_fall,
    output logic o_cs_rise,
    output logic o_cs_hi,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;
    logic                   w_sck;
    logic                   w_cs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync  <= SYNC_STAGES'({r_sck_sync, i_sck});
            r_cs_sync   <= SYNC_STAGES'({r_cs_sync, i_cs});
            r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, i_mosi});
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign o_sck_rise = w_sck & ~r_sck_d;
    assign o_sck_fall = ~w_sck & r_sck_d;
    assign o_cs_fall  = ~w_cs & r_cs_d;
    assign o_cs_rise  = w_cs & ~r_cs_d;
    assign o_cs_hi    = w_cs;
    assign o_mosi     = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder (READ/PROG/WREN/WRDI/RDSR) in front of a byte-wide memory with 1-cycle read latency.
// MISO updates SYNC_STAGES+1 clk after each SCK fall; no backpressure, SCK phases must be >= 3 clk.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_SPI_CLK,
    input  logic              i_SPI_CS,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_mem_wr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_cmd_err
);

    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_cs_hi, w_mosi;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (reset),
        .i_sck     (i_SPI_CLK),
        .i_cs      (i_SPI_CS),
        .i_mosi    (i_SPI_MOSI),
        .o_sck_rise(w_sck_rise),
        .o_sck_fall(w_sck_fall),
        .o_cs_fall (w_cs_fall),
        .o_cs_rise (w_cs_rise),
        .o_cs_hi   (w_cs_hi),
        .o_mosi    (w_mosi)
    );

    logic [2:0]        r_state;
    logic [4:0]        r_bit_cnt;
    logic [6:0]        r_rx_sh;
    logic [ADDR_W-1:0] r_addr_sh;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_tx_sh;
    logic [7:0]        r_mem_wdata;
    logic              r_wel, r_is_read, r_load, r_miso;
    logic              r_mem_rd, r_mem_wr, r_cmd_err;
    logic [7:0]        w_byte;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_byte      = {r_rx_sh, w_mosi};
    assign w_addr_next = {r_addr_sh[ADDR_W-2:0], w_mosi};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_rx_sh     <= '0;
            r_addr_sh   <= '0;
            r_addr      <= '0;
            r_tx_sh     <= '0;
            r_mem_wdata <= '0;
            r_wel       <= 1'b0;
            r_is_read   <= 1'b0;
            r_load      <= 1'b0;
            r_miso      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_cmd_err <= 1'b0;
            r_load    <= r_mem_rd;
            if (r_mem_wr)
                r_addr <= {r_addr[ADDR_W-1:8], r_addr[7:0] + 8'd1};
            // Byte completion is handled ahead of the CS check so a byte that ends as CS rises is still written.
            if (r_state == S_PROG && w_sck_rise) begin
                r_rx_sh   <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 5'd1;
                if (r_bit_cnt == 5'd7) begin
                    r_mem_wr    <= 1'b1;
                    r_mem_wdata <= w_byte;
                    r_bit_cnt   <= '0;
                end
            end
            if (w_cs_rise && r_state == S_PROG)
                r_wel <= 1'b0;
            if (w_cs_hi) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
                r_rx_sh   <= '0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_miso <= 1'b0;
                        if (w_cs_fall) begin
                            r_state   <= S_CMD;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_CMD: begin
                        r_miso <= 1'b0;
                        if (w_sck_rise) begin
                            r_rx_sh   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= '0;
                                case (w_byte)
                                    OP_READ: begin
                                        r_is_read <= 1'b1;
                                        r_state   <= S_ADDR;
                                    end
                                    OP_PROG: begin
                                        r_is_read <= 1'b0;
                                        r_state   <= r_wel ? S_ADDR : S_IGNORE;
                                    end
                                    OP_WREN: begin
                                        r_wel   <= 1'b1;
                                        r_state <= S_IGNORE;
                                    end
                                    OP_WRDI: begin
                                        r_wel   <= 1'b0;
                                        r_state <= S_IGNORE;
                                    end
                                    OP_RDSR: begin
                                        r_tx_sh <= status_byte(r_wel);
                                        r_state <= S_STATUS;
                                    end
                                    default: begin
                                        r_cmd_err <= 1'b1;
                                        r_state   <= S_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                    S_ADDR: begin
                        r_miso <= 1'b0;
                        if (w_sck_rise) begin
                            r_addr_sh <= w_addr_next;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt <= '0;
                                r_addr    <= w_addr_next;
                                r_mem_rd  <= r_is_read;
                                r_state   <= r_is_read ? S_READ : S_PROG;
                            end
                        end
                    end
                    S_READ: begin
                        if (w_sck_rise) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= '0;
                                r_addr    <= r_addr + ADDR_W'(1);
                                r_mem_rd  <= 1'b1;
                            end
                        end
                        if (w_sck_fall) begin
                            r_miso  <= r_tx_sh[7];
                            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                        end
                    end
                    S_STATUS: begin
                        // Rotating the shifter repeats the status byte for as long as SCK runs.
                        if (w_sck_fall) begin
                            r_miso  <= r_tx_sh[7];
                            r_tx_sh <= {r_tx_sh[6:0], r_tx_sh[7]};
                        end
                    end
                    default: r_miso <= 1'b0;
                endcase
            end
            if (r_load)
                r_tx_sh <= i_mem_rdata;
        end
    end

    assign o_SPI_MISO  = r_miso;
    assign o_mem_addr  = r_addr;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: bit-banged SPI master plus a byte memory model and strobe logger.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_SPI_CLK = 1'b0;
    logic        i_SPI_CS = 1'b1;
    logic        i_SPI_MOSI = 1'b0;
    logic        o_SPI_MISO;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic [7:0]  i_mem_rdata = 8'h00;
    logic        o_mem_wr;
    logic [7:0]  o_mem_wdata;
    logic        o_cmd_err;

    spi_flash_responder #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_SPI_CLK  (i_SPI_CLK),
        .i_SPI_CS   (i_SPI_CS),
        .i_SPI_MOSI (i_SPI_MOSI),
        .o_SPI_MISO (o_SPI_MISO),
        .o_mem_addr (o_mem_addr),
        .o_mem_rd   (o_mem_rd),
        .i_mem_rdata(i_mem_rdata),
        .o_mem_wr   (o_mem_wr),
        .o_mem_wdata(o_mem_wdata),
        .o_cmd_err  (o_cmd_err)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_addr_q[$];
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          err_seen = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(negedge clk) begin
        if (o_mem_rd) begin
            rd_addr_q.push_back(o_mem_addr);
            i_mem_rdata = mem[o_mem_addr];
        end
        if (o_mem_wr) begin
            wr_addr_q.push_back(o_mem_addr);
            wr_data_q.push_back(o_mem_wdata);
        end
        if (o_cmd_err)
            err_seen = err_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        i_SPI_MOSI = b;
        wait_n(6);
        i_SPI_CLK = 1'b1;
        r = o_SPI_MISO;
        wait_n(6);
        i_SPI_CLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic cs_start();
        i_SPI_CS = 1'b0;
        wait_n(8);
    endtask

    task automatic cs_end();
        wait_n(6);
        i_SPI_CS = 1'b1;
        wait_n(10);
    endtask

    task automatic one_byte_cmd(input logic [7:0] op);
        logic [7:0] rx;
        cs_start();
        spi_byte(op, rx);
        cs_end();
    endtask

    task automatic rdsr(output logic [7:0] st);
        logic [7:0] rx;
        cs_start();
        spi_byte(OP_RDSR, rx);
        spi_byte(8'h00, st);
        cs_end();
    endtask

    initial begin
        logic [7:0] rx, rx2, st;
        logic       b, miso_or;
        int         base_rd, base_wr, base_err, hits;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h3AAA] = 8'hFA;
        mem[16'hFFFF] = 8'h81;
        mem[16'h0000] = 8'h7E;

        // Reset values
        wait_n(4);
        chk("rst_miso", {31'd0, o_SPI_MISO}, 32'd0);
        chk("rst_rd", {31'd0, o_mem_rd}, 32'd0);
        chk("rst_wr", {31'd0, o_mem_wr}, 32'd0);
        chk("rst_err", {31'd0, o_cmd_err}, 32'd0);
        chk("rst_addr", {16'd0, o_mem_addr}, 32'h0);
        chk("rst_wdata", {24'd0, o_mem_wdata}, 32'h0);
        reset = 1'b0;
        wait_n(6);
        chk("idle_state", {29'd0, dut.r_state}, {29'd0, S_IDLE});

        // Read 0x3AAA
        base_rd = rd_addr_q.size();
        cs_start();
        spi_byte(OP_READ, rx);
        chk("read_cmd_miso", {24'd0, rx}, 32'h0);
        spi_byte(8'h00, rx);
        spi_byte(8'h3A, rx);
        spi_byte(8'hAA, rx);
        chk("read_addr_miso", {24'd0, rx}, 32'h0);
        spi_byte(8'h00, rx);
        cs_end();
        chk("read_data", {24'd0, rx}, 32'hFA);
        hits = 0;
        for (int i = base_rd; i < rd_addr_q.size(); i++)
            if (rd_addr_q[i] == 16'h3AAA) hits++;
        chk("read_rd_count", hits, 32'd1);
        chk("read_rd_addr", {16'd0, (rd_addr_q.size() > base_rd) ? rd_addr_q[base_rd] : 16'hDEAD}, 32'h3AAA);

        // Program 0xAA at 0x3000
        base_wr = wr_addr_q.size();
        one_byte_cmd(OP_WREN);
        cs_start();
        spi_byte(OP_PROG, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h30, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'hAA, rx);
        cs_end();
        chk("prog_wr_count", wr_addr_q.size() - base_wr, 32'd1);
        if (wr_addr_q.size() > base_wr) begin
            chk("prog_wr_addr", {16'd0, wr_addr_q[base_wr]}, 32'h3000);
            chk("prog_wr_data", {24'd0, wr_data_q[base_wr]}, 32'hAA);
        end
        rdsr(st);
        chk("prog_rdsr", {24'd0, st}, 32'h00);

        // Write protect
        base_wr = wr_addr_q.size();
        cs_start();
        spi_byte(OP_PROG, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h30, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h55, rx);
        cs_end();
        chk("wp_wr_count", wr_addr_q.size() - base_wr, 32'd0);
        one_byte_cmd(OP_WREN);
        cs_start();
        spi_byte(OP_RDSR, rx);
        spi_byte(8'h00, st);
        spi_byte(8'h00, rx2);
        cs_end();
        chk("wren_rdsr", {24'd0, st}, 32'h02);
        chk("wren_rdsr_repeat", {24'd0, rx2}, 32'h02);
        one_byte_cmd(OP_WRDI);
        rdsr(st);
        chk("wrdi_rdsr", {24'd0, st}, 32'h00);

        // Page wrap on program, full wrap on read
        base_wr = wr_addr_q.size();
        one_byte_cmd(OP_WREN);
        cs_start();
        spi_byte(OP_PROG, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h30, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        cs_end();
        chk("wrap_wr_count", wr_addr_q.size() - base_wr, 32'd2);
        if (wr_addr_q.size() >= base_wr + 2) begin
            chk("wrap_wr0_addr", {16'd0, wr_addr_q[base_wr]}, 32'h30FF);
            chk("wrap_wr0_data", {24'd0, wr_data_q[base_wr]}, 32'h11);
            chk("wrap_wr1_addr", {16'd0, wr_addr_q[base_wr+1]}, 32'h3000);
            chk("wrap_wr1_data", {24'd0, wr_data_q[base_wr+1]}, 32'h22);
        end
        base_rd = rd_addr_q.size();
        cs_start();
        spi_byte(OP_READ, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx2);
        cs_end();
        chk("wrap_rd_byte0", {24'd0, rx}, 32'h81);
        chk("wrap_rd_byte1", {24'd0, rx2}, 32'h7E);
        chk("wrap_rd_addr0", {16'd0, (rd_addr_q.size() > base_rd) ? rd_addr_q[base_rd] : 16'hDEAD}, 32'hFFFF);
        chk("wrap_rd_addr1", {16'd0, (rd_addr_q.size() > base_rd + 1) ? rd_addr_q[base_rd+1] : 16'hDEAD}, 32'h0000);

        // Unsupported opcode
        base_err = err_seen;
        base_rd  = rd_addr_q.size();
        base_wr  = wr_addr_q.size();
        miso_or  = 1'b0;
        cs_start();
        spi_byte(8'h9F, rx);
        spi_byte(8'hFF, rx2);
        for (int i = 0; i < 8; i++) begin
            spi_bit(1'b1, b);
            miso_or = miso_or | b;
        end
        cs_end();
        chk("err_pulse_count", err_seen - base_err, 32'd1);
        chk("err_miso_b0", {24'd0, rx}, 32'h0);
        chk("err_miso_b1", {24'd0, rx2}, 32'h0);
        chk("err_miso_b2", {31'd0, miso_or}, 32'd0);
        chk("err_no_strobes", (rd_addr_q.size() - base_rd) + (wr_addr_q.size() - base_wr), 32'd0);

        // Reset on the 12th address bit
        base_rd = rd_addr_q.size();
        base_wr = wr_addr_q.size();
        cs_start();
        spi_byte(OP_READ, rx);
        spi_byte(8'h00, rx);
        spi_bit(1'b0, b);
        spi_bit(1'b0, b);
        spi_bit(1'b1, b);
        spi_bit(1'b1, b);
        reset = 1'b1;
        wait_n(3);
        reset = 1'b0;
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        spi_byte(8'hAA, rx);
        spi_byte(8'h00, rx);
        chk("abort_state", {29'd0, dut.r_state}, {29'd0, S_IDLE});
        chk("abort_miso", {24'd0, rx}, 32'h0);
        cs_end();
        chk("abort_no_strobes", (rd_addr_q.size() - base_rd) + (wr_addr_q.size() - base_wr), 32'd0);
        cs_start();
        spi_byte(OP_READ, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h3A, rx);
        spi_byte(8'hAA, rx);
        spi_byte(8'h00, rx);
        cs_end();
        chk("post_abort_read", {24'd0, rx}, 32'hFA);

        // Partial byte discarded, WEL cleared
        base_wr = wr_addr_q.size();
        one_byte_cmd(OP_WREN);
        cs_start();
        spi_byte(OP_PROG, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h30, rx);
        spi_byte(8'h00, rx);
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        spi_bit(1'b1, b);
        spi_bit(1'b0, b);
        cs_end();
        chk("partial_wr_count", wr_addr_q.size() - base_wr, 32'd0);
        rdsr(st);
        chk("partial_rdsr", {24'd0, st}, 32'h00);

        // CS rises together with the 8th SCK rise of a data byte
        base_wr = wr_addr_q.size();
        one_byte_cmd(OP_WREN);
        cs_start();
        spi_byte(OP_PROG, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h30, rx);
        spi_byte(8'h10, rx);
        for (int i = 7; i >= 1; i--) spi_bit(((8'h3C >> i) & 8'h01) != 8'h00, b);
        i_SPI_MOSI = 1'b0;
        wait_n(6);
        i_SPI_CLK = 1'b1;
        i_SPI_CS  = 1'b1;
        wait_n(6);
        i_SPI_CLK = 1'b0;
        wait_n(10);
        chk("edge_wr_count", wr_addr_q.size() - base_wr, 32'd1);
        if (wr_addr_q.size() > base_wr) begin
            chk("edge_wr_addr", {16'd0, wr_addr_q[base_wr]}, 32'h3010);
            chk("edge_wr_data", {24'd0, wr_data_q[base_wr]}, 32'h3C);
        end
        rdsr(st);
        chk("edge_rdsr", {24'd0, st}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
